fp32_divider_unit: RTL and testbench

- Sequential IEEE-754 single-precision divider, dataR = dataA / dataB.
- Sits beside the combinational multiplier unit in the arithmetic datapath and uses the same 32-bit operand/result format.
- Computes one quotient bit per cycle with a restoring mantissa divider, then rounds round-to-nearest-even.
- Uses a start/busy/done handshake with fixed, documented latency.

---
 rtl/fp32_divider_unit.sv | 198 +++++++++++++++++++
 tb/tb_fp32_divider_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fp32_divider_unit.sv
// Sequential IEEE-754 single-precision divider: dataR = dataA / dataB.
// Restoring mantissa division (one quotient bit per cycle), then
// round-to-nearest-even. Denormal inputs are flushed to zero and no
// denormal results are produced. Fixed 31-cycle latency from an
// accepted start to done. When EARLY_SPECIAL is set, special operands
// finish in 2 cycles instead.
module fp32_divider_unit #(
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR,
  output logic        invalid,
  output logic        divzero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIVIDE, S_NORM, S_ROUND, S_DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic [24:0]        rem;
  logic [26:0]        q;
  logic [4:0]         cnt;
  logic signed [9:0]  e;

  // Operand fields and classes, taken from the captured operands.
  // They stay valid for the whole operation, so the special result can
  // be picked in either CHECK or ROUND without extra storage.
  logic [7:0]  a_exp, b_exp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
  logic [23:0] mb;

  assign a_exp  = a_r[30:23];
  assign b_exp  = b_r[30:23];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_r[22:0] != 23'd0);
  assign sign   = a_r[31] ^ b_r[31];
  assign mb     = {1'b1, b_r[22:0]};

  logic        is_special;
  logic [31:0] spec_data;
  logic [3:0]  spec_flags;   // {invalid, divzero, overflow, underflow}

  // Special-operand classification in priority order.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    is_special = 1'b1;
    spec_data  = 32'd0;
    spec_flags = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_data  = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_data  = {sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_data  = {sign, 8'hFF, 23'd0};
      spec_flags = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_data  = {sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift.
  logic        rem_ge;
  logic [24:0] rem_sub, rem_next;

  always_comb begin
    rem_ge   = (rem >= {1'b0, mb});
    rem_sub  = rem_ge ? (rem - {1'b0, mb}) : rem;
    rem_next = rem_sub << 1;
  end

  // Round-to-nearest-even on the normalised quotient, then range check.
  logic [23:0]       mant;
  logic              guard, sticky, round_up;
  logic [24:0]       mant_rnd;
  logic [22:0]       frac_fin;
  logic signed [9:0] e_fin;
  logic [31:0]       norm_data;
  logic [3:0]        norm_flags;

  always_comb begin
    mant     = q[26:3];
    guard    = q[2];
    sticky   = (|q[1:0]) | (|rem);
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      frac_fin = mant_rnd[23:1];
      e_fin    = e + 10'sd1;
    end else begin
      frac_fin = mant_rnd[22:0];
      e_fin    = e;
    end
    norm_flags = 4'b0000;
    if (e_fin >= 10'sd255) begin
      norm_data  = {sign, 8'hFF, 23'd0};
      norm_flags = 4'b0010;
    end else if (e_fin <= 10'sd0) begin
      norm_data  = {sign, 31'd0};
      norm_flags = 4'b0001;
    end else begin
      norm_data  = {sign, e_fin[7:0], frac_fin};
    end
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= S_IDLE;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      rem       <= 25'd0;
      q         <= 27'd0;
      cnt       <= 5'd0;
      e         <= 10'sd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dataR     <= 32'd0;
      {invalid, divzero, overflow, underflow} <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= dataA;
            b_r   <= dataB;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          rem <= {2'b01, a_r[22:0]};
          cnt <= 5'd0;
          e   <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
          if (EARLY_SPECIAL && is_special) begin
            dataR <= spec_data;
            {invalid, divzero, overflow, underflow} <= spec_flags;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          q   <= {q[25:0], rem_ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd26) state <= S_NORM;
        end
        S_NORM: begin
          if (!q[26]) begin
            q <= {q[25:0], 1'b0};
            e <= e - 10'sd1;
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          if (is_special) begin
            dataR <= spec_data;
            {invalid, divzero, overflow, underflow} <= spec_flags;
          end else begin
            dataR <= norm_data;
            {invalid, divzero, overflow, underflow} <= norm_flags;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider_unit.sv
// Bench for fp32_divider_unit: two instances (early-special and
// constant-time) share stimulus; expected results are queued per
// instance when an operation starts and popped when its done fires.
module tb_fp32_divider_unit;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  logic        clk, rst_n, start;
  logic [31:0] data_a, data_b;

  logic        busy1, done1, inv1, dz1, ovf1, unf1;
  logic [31:0] res1;
  logic        busy0, done0, inv0, dz0, ovf0, unf0;
  logic [31:0] res0;

  exp_t sb1[$];
  exp_t sb0[$];

  int n_checks = 0;
  int n_fail   = 0;

  fp32_divider_unit #(.EARLY_SPECIAL(1'b1)) dut_early (
    .clk(clk), .rst_n(rst_n), .start(start), .dataA(data_a), .dataB(data_b),
    .busy(busy1), .done(done1), .dataR(res1),
    .invalid(inv1), .divzero(dz1), .overflow(ovf1), .underflow(unf1)
  );

  fp32_divider_unit #(.EARLY_SPECIAL(1'b0)) dut_const (
    .clk(clk), .rst_n(rst_n), .start(start), .dataA(data_a), .dataB(data_b),
    .busy(busy0), .done(done0), .dataR(res0),
    .invalid(inv0), .divzero(dz0), .overflow(ovf0), .underflow(unf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one operation (called at a negedge), follows it for 32 cycles,
  // optionally pulses start in cycle extra_cyc, and scores both instances.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_f,
                        input bit spec, input int extra_cyc);
    exp_t ex;
    int   busy_bad = 0;
    sb1.push_back('{tag, exp_r, exp_f, spec ? 2 : 31});
    sb0.push_back('{tag, exp_r, exp_f, 31});
    start  = 1'b1;
    data_a = a;
    data_b = b;
    @(posedge clk);                       // edge 0: start accepted
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start  = 1'b0;
        data_a = 32'h4120_0000;           // inputs change after capture
        data_b = 32'h3F80_0000;
      end
      if (extra_cyc != 0 && cyc == extra_cyc) begin
        start  = 1'b1;
        data_a = 32'h4000_0000;
        data_b = 32'h4000_0000;
      end
      if (extra_cyc != 0 && cyc == extra_cyc + 1) start = 1'b0;
      if (busy1 !== (cyc <= (spec ? 2 : 31))) busy_bad++;
      if (busy0 !== (cyc <= 31)) busy_bad++;
      if (done1 === 1'b1) begin
        check({tag, "_e1_pending"}, 32'(sb1.size()), 32'd1);
        if (sb1.size() > 0) begin
          ex = sb1.pop_front();
          check({ex.tag, "_e1_latency"}, 32'(cyc), 32'(ex.lat));
          check({ex.tag, "_e1_data"}, res1, ex.data);
          check({ex.tag, "_e1_flags"}, 32'({inv1, dz1, ovf1, unf1}), 32'(ex.flags));
        end
      end
      if (done0 === 1'b1) begin
        check({tag, "_e0_pending"}, 32'(sb0.size()), 32'd1);
        if (sb0.size() > 0) begin
          ex = sb0.pop_front();
          check({ex.tag, "_e0_latency"}, 32'(cyc), 32'(ex.lat));
          check({ex.tag, "_e0_data"}, res0, ex.data);
          check({ex.tag, "_e0_flags"}, 32'({inv0, dz0, ovf0, unf0}), 32'(ex.flags));
        end
      end
    end
    check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    check({tag, "_e1_done_seen"}, 32'(sb1.size()), 32'd0);
    check({tag, "_e0_done_seen"}, 32'(sb0.size()), 32'd0);
    check({tag, "_e1_held"}, res1, exp_r);
    sb1.delete();
    sb0.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    data_a = 32'd0;
    data_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_e1", 32'({busy1, done1, inv1, dz1, ovf1, unf1}), 32'd0);
    check("reset_e1_data", res1, 32'd0);
    check("reset_e0", 32'({busy0, done0, inv0, dz0, ovf0, unf0}), 32'd0);
    check("reset_e0_data", res0, 32'd0);
    rst_n = 1'b1;

    // Normal path, including ignored starts while busy and in DONE;
    // "one_one" is accepted in the cycle right after a DONE.
    run_op("six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b0, 0);
    run_op("one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 1'b0, 10);
    run_op("done_ignore", 32'hC120_0000, 32'h4080_0000, 32'hC020_0000, 4'b0000, 1'b0, 31);
    run_op("one_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 1'b0, 0);

    // Special operands.
    run_op("div_zero",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1'b1, 0);
    run_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1'b1, 0);
    run_op("x_by_inf",    32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000, 1'b1, 0);
    run_op("nan_in",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1, 0);
    run_op("inf_by_x",    32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1'b1, 0);

    // Range limits.
    run_op("overflow",    32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 4'b0010, 1'b0, 0);
    run_op("underflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 1'b0, 0);

    // Reset in the middle of an operation.
    start  = 1'b1;
    data_a = 32'h3F80_0000;
    data_b = 32'h4040_0000;
    @(posedge clk);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 15) rst_n = 1'b0;
    end
    @(negedge clk);
    check("midop_reset_e1", 32'({busy1, done1, inv1, dz1, ovf1, unf1}), 32'd0);
    check("midop_reset_e1_data", res1, 32'd0);
    check("midop_reset_e0", 32'({busy0, done0, inv0, dz0, ovf0, unf0}), 32'd0);
    check("midop_reset_e0_data", res0, 32'd0);
    rst_n = 1'b1;

    run_op("after_reset", 32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 4'b0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
